// File: rtl/mole_picker_if.sv
// Request/response bundle between the mole picker and its requester/random source.
interface mole_picker_if;
  logic [7:0] rand_data;
  logic [3:0] num_moles;
  logic       req;
  logic       busy;
  logic       mole_valid;
  logic [3:0] mole_idx;
  logic       fallback;

  modport slave (
    input  rand_data, num_moles, req,
    output busy, mole_valid, mole_idx, fallback
  );

  modport master (
    output rand_data, num_moles, req,
    input  busy, mole_valid, mole_idx, fallback
  );
endinterface

// File: rtl/mole_picker.sv
// Picks a random mole index in 0..N-1 that differs from the previous pick,
// retrying on rejected bytes and falling back to last_idx+1 after MAX_RETRIES rejects.
module mole_picker #(
  parameter int unsigned MAX_RETRIES = 7
) (
  input  logic          clock,
  input  logic          resetn,
  mole_picker_if.slave  bus
);

  localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         n_q, n_d;
  logic [3:0]         last_q, last_d;
  logic [3:0]         idx_q, idx_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               fb_q, fb_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;

  logic [3:0] cand_c;
  logic       accept_c;
  logic [4:0] fb_sum_c;
  logic [3:0] fb_idx_c;
  logic       unused_rand_hi;

  assign cand_c         = bus.rand_data[3:0];
  assign unused_rand_hi = ^bus.rand_data[7:4];

  // With a single mole there is nothing to avoid repeating.
  assign accept_c = (cand_c < n_q) && ((n_q == 4'd1) || (cand_c != last_q));
  assign fb_sum_c = 5'(last_q) + 5'd1;
  assign fb_idx_c = (5'(last_q) >= (5'(n_q) - 5'd1)) ? 4'd0 : fb_sum_c[3:0];

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    last_d  = last_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    fb_d    = fb_q;

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          n_d     = (bus.num_moles == 4'd0) ? 4'd1 : bus.num_moles;
          retry_d = '0;
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (accept_c) begin
          idx_d   = cand_c;
          fb_d    = 1'b0;
          state_d = DONE;
        end else if (retry_q >= RETRY_LAST) begin
          idx_d   = fb_idx_c;
          fb_d    = 1'b1;
          state_d = DONE;
        end else begin
          retry_d = retry_q + RETRY_W'(1);
        end
      end
      DONE: begin
        last_d  = idx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      n_q     <= 4'd1;
      last_q  <= 4'd0;
      idx_q   <= 4'd0;
      retry_q <= '0;
      fb_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      fb_q    <= fb_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.mole_valid = valid_q;
  assign bus.mole_idx   = idx_q;
  assign bus.fallback   = fb_q;

endmodule

// File: doc/mole_picker.md
MOLE_PICKER -- requirements
Module: mole_picker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 The block SHALL have the parameter MAX_RETRIES, default 7, meaning the number of rejected samples allowed before the fallback index is used.
REQ-003 clock  input  1  rising-edge system clock, shared with the random8 generator.
REQ-004 resetn  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-005 rand_data  input  8  random byte from the generator; the generator advances on every clock edge.
REQ-006 num_moles  input  4  number of active moles; legal range 1..15; the value 0 SHALL be treated as 1.
REQ-007 req  input  1  level request for a new mole index; sampled only in IDLE.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 mole_valid  output  1  one-cycle pulse; mole_idx is valid while it is high.
REQ-010 mole_idx  output  4  selected mole index, always in the range 0..N-1.
REQ-011 fallback  output  1  high together with mole_valid when the index came from the retry-limit path.

Function
REQ-012 The FSM SHALL have the states IDLE, SAMPLE, DONE, encoded in 2 bits; the unused encoding SHALL go to IDLE.
REQ-013 IDLE: when req=1 at a clock edge, the block SHALL latch N = max(num_moles,1), clear retry_cnt to 0, and go to SAMPLE.
REQ-014 IDLE: when req=0, the block SHALL stay in IDLE.
REQ-015 N SHALL be held constant from the latch point until the return to IDLE; later changes on num_moles SHALL have no effect.
REQ-016 SAMPLE: candidate c = rand_data[3:0], taken combinationally in the current cycle.
REQ-017 SAMPLE: c SHALL be accepted when c < N and, if N > 1, c != last_idx.
REQ-018 SAMPLE: when N = 1, c SHALL be accepted when c = 0, with no repeat check.
REQ-019 SAMPLE, accept: the block SHALL register mole_idx = c and fallback = 0, then go to DONE.
REQ-020 SAMPLE, reject with retry_cnt < MAX_RETRIES-1: the block SHALL increment retry_cnt and stay in SAMPLE; a new byte is used each cycle.
REQ-021 SAMPLE, reject with retry_cnt = MAX_RETRIES-1: the block SHALL register mole_idx = (last_idx+1) mod N, or 0 when N = 1, set fallback = 1, and go to DONE.
REQ-022 retry_cnt SHALL be ceil(log2(MAX_RETRIES+1)) bits wide and SHALL never wrap.
REQ-023 DONE: mole_valid SHALL be high for exactly this one cycle, and the block SHALL go to IDLE.
REQ-024 DONE: last_idx SHALL be updated to mole_idx at the end of the DONE cycle.
REQ-025 mole_idx and fallback SHALL hold their values after DONE until the next DONE.
REQ-026 Latency from the req sampling edge to mole_valid high SHALL be 2 cycles minimum and MAX_RETRIES+1 cycles maximum.
REQ-027 A req that is still high in the cycle after DONE SHALL start a new pick; back-to-back throughput is 1 pick per 3 cycles minimum.
REQ-028 A req that toggles while busy=1 SHALL be ignored; there SHALL be no queueing.
REQ-029 If last_idx >= N because N was reduced, the repeat check SHALL still compare c != last_idx.
REQ-030 The fallback computation SHALL use (last_idx+1) mod N computed on a 5-bit sum; if last_idx >= N-1, the result SHALL be 0.
REQ-031 rand_data[7:4] SHALL be unused.

Reset
REQ-032 resetn=0 at a clock edge SHALL force state=IDLE, busy=0, mole_valid=0, mole_idx=0, fallback=0, retry_cnt=0, last_idx=0, N=1.
REQ-033 Reset SHALL take priority over every transition, including when it is applied mid-SAMPLE or in DONE.
REQ-034 No mole_valid pulse SHALL be issued for a pick that is interrupted by reset.
REQ-035 After resetn is released, the first req SHALL behave exactly as after power-up.

Verification
REQ-036 Accept: after reset, num_moles=9, req pulse, rand_data=0x05 -> mole_valid 2 cycles later, mole_idx=5, fallback=0, busy high for exactly 2 cycles.
REQ-037 Reject, then accept: last_idx=5, N=9, rand_data sequence 0x0C, 0x05, 0x03 -> mole_valid on the 4th cycle after req, mole_idx=3.
REQ-038 Retry limit: last_idx=8, N=9, rand_data held at 0x0F, MAX_RETRIES=7 -> mole_valid 8 cycles after req, mole_idx=0, fallback=1.
REQ-039 Degenerate N: num_moles=0, req, rand_data 0x03 then 0x00 -> mole_idx=0 after 1 retry; repeated picks may return 0 again.
REQ-040 Mid-operation reset: resetn=0 asserted during the 3rd SAMPLE cycle -> next cycle busy=0, mole_idx=0; no mole_valid pulse; the next pick then works normally.
REQ-041 Continuous req held high: 10 picks with random rand_data -> consecutive mole_idx values always differ, every value is < N, and mole_valid is never high in 2 consecutive cycles.
